piso_tx_ctrl: RTL and testbench

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

---
 rtl/piso_ctrl_pkg.sv | 18 +
 rtl/piso_shifter.sv | 27 ++
 rtl/piso_tx_ctrl.sv | 125 ++++++++++++
 tb/tb_piso_tx_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/piso_ctrl_pkg.sv
// Shared types and constants for the PISO serial transmit controller.
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, MSB-first shift register; zeros fill from the LSB end.
module piso_shifter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              sh,
  input  logic [DATA_W-1:0] din,
  output logic              q_msb
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (ld) begin
      q_q <= din;
    end else if (sh) begin
      q_q <= {q_q[DATA_W-2:0], 1'b0};
    end
  end

  assign q_msb = q_q[DATA_W-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Frame FSM, baud/bit counters and valid/ready handshake for a start/data/stop serializer.
module piso_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BAUD_W = cnt_width(BAUD_DIV);
  localparam int unsigned BIT_W  = cnt_width(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              live_q;
  logic              ld, sh, q_msb, accept, boundary;
  logic [DATA_W-1:0] din;

  // Holds in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      live_q  <= 1'b1;
    end
  end

  assign in_ready = live_q && (state_q == IDLE);
  assign accept   = in_ready && in_valid && !abort;
  assign boundary = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    ld      = 1'b0;
    sh      = 1'b0;
    din     = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          baud_d  = BAUD_MAX;
          ld      = 1'b1;
          din     = in_data;
        end
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          baud_d  = BAUD_MAX;
          bit_d   = BIT_MAX;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (boundary) begin
          baud_d = BAUD_MAX;
          sh     = 1'b1;
          if (bit_q == '0) state_d = STOP;
          else             bit_d   = bit_q - 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (boundary) state_d = IDLE;
        else          baud_d  = baud_q - 1'b1;
      end
    endcase
    // Cancel: return to IDLE and load zeros to clear the shifter.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      baud_d  = '0;
      bit_d   = '0;
      ld      = 1'b1;
      sh      = 1'b0;
      din     = '0;
    end
  end

  piso_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .sh   (sh),
    .din  (din),
    .q_msb(q_msb)
  );

  always_comb begin
    sout = IDLE_LEVEL;
    unique case (state_q)
      IDLE:  sout = IDLE_LEVEL;
      START: sout = ~IDLE_LEVEL;
      DATA:  sout = q_msb;
      STOP:  sout = IDLE_LEVEL;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == STOP) && boundary;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench: DATA_W=8 with BAUD_DIV=4 and BAUD_DIV=1 instances.
module tb_piso_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data0, in_data1;
  logic       in_valid0, in_valid1, abort0, abort1;
  logic       in_ready0, in_ready1, sout0, sout1, busy0, busy1, done0, done1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.DATA_W(8), .BAUD_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .abort(abort0), .sout(sout0), .busy(busy0), .done(done0)
  );

  piso_tx_ctrl #(.DATA_W(8), .BAUD_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .abort(abort1), .sout(sout1), .busy(busy1), .done(done1)
  );

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] pat;  // expected line bits, pat[9] sent first
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks cycles 1..40 of a BAUD_DIV=4 frame; returns sampled at cycle 41.
  task automatic check_frame0(input string name, input logic [9:0] pat);
    for (int c = 1; c <= 40; c++) begin
      chk({name, "_sout"}, 32'(sout0), 32'(pat[9 - (c - 1) / 4]));
      chk({name, "_busy"}, 32'(busy0), 32'd1);
      chk({name, "_done"}, 32'(done0), 32'(c == 40));
      chk({name, "_rdy"},  32'(in_ready0), 32'd0);
      tick();
    end
  endtask

  task automatic check_idle0(input string name);
    chk({name, "_idle_rdy"},  32'(in_ready0), 32'd1);
    chk({name, "_idle_busy"}, 32'(busy0), 32'd0);
    chk({name, "_idle_sout"}, 32'(sout0), 32'd1);
    chk({name, "_idle_done"}, 32'(done0), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"a5", 8'hA5, 10'b0_10100101_1};
    vecs[1] = '{"ff", 8'hFF, 10'b0_11111111_1};
    vecs[2] = '{"00", 8'h00, 10'b0_00000000_1};
    vecs[3] = '{"3c", 8'h3C, 10'b0_00111100_1};
    vecs[4] = '{"81", 8'h81, 10'b0_10000001_1};

    rst = 1'b1;
    in_data0 = '0; in_valid0 = 1'b0; abort0 = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; abort1 = 1'b0;
    #1;
    chk("rst_rdy",  32'(in_ready0), 32'd0);
    chk("rst_sout", 32'(sout0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1 chk("rel_rdy_before_edge", 32'(in_ready0), 32'd0);
    tick();
    chk("rel_rdy_after_edge", 32'(in_ready0), 32'd1);
    chk("rel_rdy1_after_edge", 32'(in_ready1), 32'd1);

    // Stall in IDLE
    for (int i = 0; i < 20; i++) begin
      chk("stall_sout", 32'(sout0), 32'd1);
      chk("stall_busy", 32'(busy0), 32'd0);
      chk("stall_done", 32'(done0), 32'd0);
      tick();
    end

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      chk({vecs[v].name, "_pre_rdy"}, 32'(in_ready0), 32'd1);
      in_data0 = vecs[v].data;
      in_valid0 = 1'b1;
      tick();
      in_valid0 = 1'b0;
      check_frame0(vecs[v].name, vecs[v].pat);
      check_idle0(vecs[v].name);
      tick();
    end

    // Back-to-back: valid held high, second accept 41 edges after the first
    in_data0 = 8'hFF;
    in_valid0 = 1'b1;
    tick();
    in_data0 = 8'h00;
    check_frame0("b2b_ff", 10'b0_11111111_1);
    chk("b2b_gap_rdy", 32'(in_ready0), 32'd1);
    chk("b2b_gap_busy", 32'(busy0), 32'd0);
    tick();
    in_valid0 = 1'b0;
    check_frame0("b2b_00", 10'b0_00000000_1);
    check_idle0("b2b");
    tick();

    // Abort in IDLE with valid: no acceptance
    in_data0 = 8'h55;
    in_valid0 = 1'b1;
    abort0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    abort0 = 1'b0;
    chk("idle_abort_busy", 32'(busy0), 32'd0);
    chk("idle_abort_rdy",  32'(in_ready0), 32'd1);

    // Abort at cycle 15 of a 3C frame
    in_data0 = 8'h3C;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      chk("abort_sout", 32'(sout0), 32'(vecs[3].pat[9 - (c - 1) / 4]));
      chk("abort_done", 32'(done0), 32'd0);
      if (c == 15) abort0 = 1'b1;
      tick();
    end
    abort0 = 1'b0;
    chk("abort_c16_busy", 32'(busy0), 32'd0);
    chk("abort_c16_sout", 32'(sout0), 32'd1);
    chk("abort_c16_rdy",  32'(in_ready0), 32'd1);
    for (int i = 0; i < 45; i++) begin
      chk("abort_no_done", 32'(done0), 32'd0);
      chk("abort_stay_idle", 32'(busy0), 32'd0);
      tick();
    end

    // Async reset mid-DATA of an 00 frame (sout low at cycle 10)
    in_data0 = 8'h00;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("arst_pre_sout", 32'(sout0), 32'd0);
    chk("arst_pre_busy", 32'(busy0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sout", 32'(sout0), 32'd1);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_rdy",  32'(in_ready0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    tick();
    #2 rst = 1'b0;
    #1 chk("arst_rel_rdy_before", 32'(in_ready0), 32'd0);
    tick();
    chk("arst_rel_rdy_after", 32'(in_ready0), 32'd1);
    for (int i = 0; i < 45; i++) begin
      chk("arst_no_done", 32'(done0), 32'd0);
      chk("arst_sout_idle", 32'(sout0), 32'd1);
      tick();
    end

    // BAUD_DIV=1 instance: 81 frame, ten cycles
    in_data1 = 8'h81;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("bd1_sout", 32'(sout1), 32'(vecs[4].pat[10 - c]));
      chk("bd1_busy", 32'(busy1), 32'd1);
      chk("bd1_done", 32'(done1), 32'(c == 10));
      tick();
    end
    chk("bd1_idle_rdy",  32'(in_ready1), 32'd1);
    chk("bd1_idle_busy", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
